// File: rtl/oled_sink_pkg.sv
// oled_sink_pkg: shared decoder states, addressing modes and opcodes for the OLED SPI sink.
package oled_sink_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ARG1, ST_COL_S, ST_COL_E, ST_PG_S, ST_PG_E} dec_state_t;
  typedef enum logic {MODE_HORZ, MODE_PAGE} addr_mode_t;
  localparam logic [7:0] OP_MODE      = 8'h20;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISP_ON   = 8'hAF;
  localparam logic [7:0] OP_PAGE_BASE = 8'hB0;
  localparam logic [7:0] ONE_ARG_OPS [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
  function automatic logic is_one_arg(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++) hit |= (b == ONE_ARG_OPS[i]);
    return hit;
  endfunction
endpackage

// File: rtl/oled_spi_deser.sv
// oled_spi_deser: synchronizes the 4-wire SPI inputs and assembles MSB-first bytes,
// flagging frames that end with a partial byte.
module oled_spi_deser
  import oled_sink_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       SDIN,
  input  logic       DC,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_frag_err
);
  logic [3:0] r_sync [SYNC_STAGES];
  logic       r_sclk_q;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;
  logic       w_cs, w_sclk, w_sdin, w_dc, w_rise;
  logic [7:0] w_next;
  assign {w_cs, w_sclk, w_sdin, w_dc} = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_q & ~w_cs;
  assign w_next = {r_shift, w_sdin};
  // Idle bus levels (CS and SCLK high) on reset so release cannot fake an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b1100;
      r_sclk_q     <= 1'b1;
      r_shift      <= '0;
      r_cnt        <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
      o_dc         <= 1'b0;
      o_frag_err   <= 1'b0;
    end else begin
      r_sync[0] <= {CS, SCLK, SDIN, DC};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_q     <= w_sclk;
      o_byte_valid <= w_rise && r_cnt == 3'd7;
      o_frag_err   <= w_cs && r_cnt != 3'd0;
      if (w_cs) r_cnt <= '0;
      else if (w_rise) begin
        r_shift <= w_next[6:0];
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          o_byte <= w_next;
          o_dc   <= w_dc;
        end
      end
    end
  end
endmodule

// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SSD1306-style SPI slave model; decodes the controller's command subset,
// tracks column/page pointers and emits frame-buffer write strobes.
module oled_spi_sink
  import oled_sink_pkg::*;
#(
  parameter int NUM_PAGES   = 4,
  parameter int NUM_COLS    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CS,
  input  logic                         SCLK,
  input  logic                         SDIN,
  input  logic                         DC,
  output logic                         wr_en,
  output logic [$clog2(NUM_PAGES)-1:0] wr_page,
  output logic [$clog2(NUM_COLS)-1:0]  wr_col,
  output logic [7:0]                   wr_data,
  output logic                         cmd_valid,
  output logic [7:0]                   cmd_byte,
  output logic                         cmd_is_arg,
  output logic                         disp_on,
  output logic                         frame_done,
  output logic                         frag_err
);
  localparam int PW = $clog2(NUM_PAGES);
  localparam int CW = $clog2(NUM_COLS);
  logic          w_bv, w_dc;
  logic [7:0]    w_byte, w_col8;
  dec_state_t    r_state, w_state;
  addr_mode_t    r_mode, w_mode;
  logic [7:0]    r_op, w_op;
  logic [CW-1:0] r_col_start, r_col_end, r_col, w_col_start, w_col_end, w_col, w_wr_col;
  logic [PW-1:0] r_page_start, r_page_end, r_page, w_page_start, w_page_end, w_page, w_wr_page;
  logic          w_wr_en, w_cmd_valid, w_cmd_is_arg, w_disp_on, w_frame_done, w_at_ce, w_at_pe;
  logic [7:0]    w_wr_data, w_cmd_byte;
  oled_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .SDIN(SDIN), .DC(DC),
    .o_byte_valid(w_bv), .o_byte(w_byte), .o_dc(w_dc), .o_frag_err(frag_err)
  );
  assign w_col8  = 8'(r_col);
  assign w_at_ce = r_col == r_col_end;
  assign w_at_pe = r_page == r_page_end;
  always_comb begin
    w_state      = r_state;
    w_op         = r_op;
    w_mode       = r_mode;
    w_col_start  = r_col_start;
    w_col_end    = r_col_end;
    w_page_start = r_page_start;
    w_page_end   = r_page_end;
    w_col        = r_col;
    w_page       = r_page;
    w_wr_en      = 1'b0;
    w_wr_page    = wr_page;
    w_wr_col     = wr_col;
    w_wr_data    = wr_data;
    w_cmd_valid  = 1'b0;
    w_cmd_byte   = cmd_byte;
    w_cmd_is_arg = cmd_is_arg;
    w_disp_on    = disp_on;
    w_frame_done = 1'b0;
    // A data byte always wins: it aborts any pending argument sequence.
    if (w_bv && w_dc) begin
      w_state   = ST_IDLE;
      w_wr_en   = 1'b1;
      w_wr_page = r_page;
      w_wr_col  = r_col;
      w_wr_data = w_byte;
      w_col     = w_at_ce ? r_col_start : CW'(r_col + 1);
      if (r_mode == MODE_HORZ && w_at_ce) begin
        w_page       = w_at_pe ? r_page_start : PW'(r_page + 1);
        w_frame_done = w_at_pe;
      end
    end else if (w_bv) begin
      w_cmd_valid  = 1'b1;
      w_cmd_byte   = w_byte;
      w_cmd_is_arg = r_state != ST_IDLE;
      case (r_state)
        ST_ARG1: begin
          w_state = ST_IDLE;
          if (r_op == OP_MODE) w_mode = (w_byte[1:0] == 2'b00) ? MODE_HORZ : MODE_PAGE;
        end
        ST_COL_S: begin
          w_state     = ST_COL_E;
          w_col_start = CW'(w_byte);
        end
        ST_COL_E: begin
          w_state   = ST_IDLE;
          w_col_end = CW'(w_byte);
          w_col     = r_col_start;
        end
        ST_PG_S: begin
          w_state      = ST_PG_E;
          w_page_start = PW'(w_byte);
        end
        ST_PG_E: begin
          w_state    = ST_IDLE;
          w_page_end = PW'(w_byte);
          w_page     = r_page_start;
        end
        default: begin
          if (is_one_arg(w_byte)) begin
            w_state = ST_ARG1;
            w_op    = w_byte;
          end
          else if (w_byte == OP_COL_ADDR) w_state = ST_COL_S;
          else if (w_byte == OP_PAGE_ADDR) w_state = ST_PG_S;
          else if (w_byte[7:4] == 4'h0) w_col = CW'({w_col8[7:4], w_byte[3:0]});
          else if (w_byte[7:4] == 4'h1) w_col = CW'({w_col8[7], w_byte[2:0], w_col8[3:0]});
          else if (w_byte[7:3] == OP_PAGE_BASE[7:3]) w_page = PW'(w_byte);
          else if (w_byte == OP_DISP_OFF || w_byte == OP_DISP_ON) w_disp_on = w_byte[0];
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_mode       <= MODE_PAGE;
      r_col_start  <= '0;
      r_col_end    <= CW'(NUM_COLS - 1);
      r_page_start <= '0;
      r_page_end   <= PW'(NUM_PAGES - 1);
      r_col        <= '0;
      r_page       <= '0;
      wr_en        <= 1'b0;
      wr_page      <= '0;
      wr_col       <= '0;
      wr_data      <= '0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= '0;
      cmd_is_arg   <= 1'b0;
      disp_on      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_op         <= w_op;
      r_mode       <= w_mode;
      r_col_start  <= w_col_start;
      r_col_end    <= w_col_end;
      r_page_start <= w_page_start;
      r_page_end   <= w_page_end;
      r_col        <= w_col;
      r_page       <= w_page;
      wr_en        <= w_wr_en;
      wr_page      <= w_wr_page;
      wr_col       <= w_wr_col;
      wr_data      <= w_wr_data;
      cmd_valid    <= w_cmd_valid;
      cmd_byte     <= w_cmd_byte;
      cmd_is_arg   <= w_cmd_is_arg;
      disp_on      <= w_disp_on;
      frame_done   <= w_frame_done;
    end
  end
endmodule
